// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage RV32M multiply/divide unit.
//   XLEN                 operand/result width (iteration count of both engines)
//   MD_*                 funct3 operation codes
//   state_t              top-level FSM encoding
//   DIV_ZERO_Q, INT_MIN  constants for the divide special cases
//   mag(), mul_pick()    sign/magnitude helpers shared by the slow and fast paths
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

  // Magnitude of v when it is to be treated as a negative signed value.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Apply the product sign, then pick the low word (MUL) or high word (MULH*).
  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p,
                                               input logic              neg,
                                               input logic [2:0]        op);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (op == MD_MUL) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

endpackage

// File: rtl/execute_muldiv_unit_if.sv
// Handshake/operand bundle between the execute stage and the mul/div unit.
//   start, funct3, SrcAE, SrcBE, kill : request side (master drives)
//   busy, done, result                : response side (slave drives)
interface execute_muldiv_unit_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, SrcAE, SrcBE, kill,
                  input  busy, done, result);
  modport slave  (input  start, funct3, SrcAE, SrcBE, kill,
                  output busy, done, result);
endinterface

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per step.
//   clk, rst_n      clock, async active-low reset
//   i_load          capture dividend/divisor and clear the partial remainder
//   i_step          perform one restoring step
//   i_dividend/i_divisor  magnitudes to divide
//   o_quot_next/o_rem_next  values the registers take on the next step, so the
//                           caller can capture the final result on the last step edge
module muldiv_div_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_quot_next,
  output logic [W-1:0] o_rem_next
);

  logic [W-1:0] r_quo;
  logic [W-1:0] r_rem;
  logic [W-1:0] r_dsr;

  logic [W:0] w_shift;
  logic [W:0] w_diff;
  logic       w_fit;

  // Dividend bits shift out of the top of r_quo while quotient bits fill the bottom.
  assign w_shift     = {r_rem, r_quo[W-1]};
  assign w_diff      = w_shift - {1'b0, r_dsr};
  assign w_fit       = ~w_diff[W];
  assign o_rem_next  = w_fit ? w_diff[W-1:0] : w_shift[W-1:0];
  assign o_quot_next = {r_quo[W-2:0], w_fit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dsr <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dsr <= i_divisor;
    end else if (i_step) begin
      r_quo <= o_quot_next;
      r_rem <= o_rem_next;
    end
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
//   clk, rst_n : clock, async active-low reset
//   bus        : execute_muldiv_unit_if.slave (start/funct3/SrcAE/SrcBE/kill in,
//                busy/done/result out)
// Build option MULDIV_FAST_MUL_EN: multiplies use one combinational XLEN x XLEN
// multiply at acceptance and finish the next cycle; divides are unaffected.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; the only state that accepts a request
// ST_MUL  | shift-add multiply, one multiplier bit per cycle
// ST_DIV  | restoring divide in muldiv_div_core, one quotient bit per cycle
// ST_DONE | done pulse and fresh result; busy still high, back to IDLE
module execute_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  execute_muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [2:0]        r_op;
  logic              r_neg;       // product / quotient sign
  logic              r_neg_rem;   // remainder follows the dividend sign
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_prod;      // {accumulator, remaining multiplier bits}
  logic [XLEN-1:0]   r_mcand;

  logic              w_is_div;
  logic              w_sign_a;
  logic              w_sign_b;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic              w_accept;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN-1:0]   w_quot_next;
  logic [XLEN-1:0]   w_rem_next;
  logic [XLEN-1:0]   w_div_res;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_prod_next;

  assign w_is_div = bus.funct3[2];
  assign w_sign_a = bus.SrcAE[XLEN-1] &&
                    (bus.funct3 inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  assign w_sign_b = bus.SrcBE[XLEN-1] &&
                    (bus.funct3 inside {MD_MULH, MD_DIV, MD_REM});
  assign w_mag_a  = mag(bus.SrcAE, w_sign_a);
  assign w_mag_b  = mag(bus.SrcBE, w_sign_b);

  assign w_div_zero = w_is_div && (bus.SrcBE == '0);
  assign w_div_ovf  = (bus.funct3 inside {MD_DIV, MD_REM}) &&
                      (bus.SrcAE == INT_MIN) && (bus.SrcBE == DIV_ZERO_Q);
  assign w_special  = w_div_zero || w_div_ovf;
  assign w_accept   = (r_state == ST_IDLE) && bus.start && !bus.kill;

  // funct3[1] distinguishes REM/REMU from DIV/DIVU.
  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = bus.funct3[1] ? bus.SrcAE : DIV_ZERO_Q;
    else if (w_div_ovf)
      w_special_res = bus.funct3[1] ? '0 : INT_MIN;
  end

  // One shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole product right keeping the carry.
  assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                       {1'b0, (r_prod[0] ? r_mcand : {XLEN{1'b0}})};
  assign w_prod_next = {w_mul_sum, r_prod[XLEN-1:1]};
  assign w_mul_res   = mul_pick(w_prod_next, r_neg, r_op);

  assign w_div_res = r_op[1] ? (r_neg_rem ? -w_rem_next  : w_rem_next)
                             : (r_neg     ? -w_quot_next : w_quot_next);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
`endif

  muldiv_div_core #(.W(XLEN)) u_div_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_accept && w_is_div && !w_special),
    .i_step      ((r_state == ST_DIV) && !bus.kill),
    .i_dividend  (w_mag_a),
    .i_divisor   (w_mag_b),
    .o_quot_next (w_quot_next),
    .o_rem_next  (w_rem_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_prod    <= '0;
      r_mcand   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_busy    <= 1'b1;
            r_op      <= bus.funct3;
            r_neg     <= w_sign_a ^ w_sign_b;
            r_neg_rem <= w_sign_a;
            r_cnt     <= CNT_W'(XLEN - 1);
            r_prod    <= {{XLEN{1'b0}}, w_mag_b};
            r_mcand   <= w_mag_a;
            if (w_special) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_result <= w_special_res;
            end else if (w_is_div) begin
              r_state <= ST_DIV;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_result <= mul_pick(w_fast_prod, w_sign_a ^ w_sign_b, bus.funct3);
`else
              r_state <= ST_MUL;
`endif
            end
          end
        end
        ST_MUL: begin
          if (bus.kill) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_prod <= w_prod_next;
            if (r_cnt == '0) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_result <= w_mul_res;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        ST_DIV: begin
          if (bus.kill) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_result <= w_div_res;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
module tb_execute_muldiv_unit;
  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m_e;
  logic [31:0] last_res = '0;

`ifdef MULDIV_FAST_MUL_EN
  localparam logic [2:0] RST_OP = MD_DIVU;
`else
  localparam logic [2:0] RST_OP = MD_MUL;
`endif

  execute_muldiv_unit_if bus ();

  execute_muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: RV32M semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ps;
    logic        [63:0] pu;
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b000: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[31:0]; end
      3'b001: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
      3'b010: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'h0, b});       return ps[63:32]; end
      3'b011: begin pu = {32'h0, a} * {32'h0, b};                               return pu[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges from acceptance to the done edge: 0 for the immediate cases, XLEN otherwise.
  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2])
      return ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : 32;
`ifdef MULDIV_FAST_MUL_EN
    return 0;
`else
    return 32;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: result %h with nothing outstanding (cycle %0d)", bus.result, cyc);
      end else begin
        m_e = sb_q.pop_front();
        if (bus.result !== m_e.res || cyc != m_e.cyc || bus.busy !== 1'b1) begin
          n_err++;
          $display("FAIL op%0d_done: got result %h at cycle %0d busy %b, expected %h at cycle %0d busy 1",
                   m_e.op, bus.result, cyc, bus.busy, m_e.res, m_e.cyc);
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) return;
      @(negedge clk);
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_idle: busy %b after 200 cycles, expected 0", bus.busy);
  endtask

  // Stay on negedges until the unit is idle; optionally throw ignored starts at it.
  task automatic drain(input bit junk);
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) begin
        bus.start = 1'b0;
        return;
      end
      if (junk) begin
        bus.start  = 1'($urandom);
        bus.funct3 = 3'($urandom);
        bus.SrcAE  = $urandom;
        bus.SrcBE  = $urandom;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_vec++;
    n_err++;
    $display("FAIL drain: busy %b after 200 cycles, expected 0", bus.busy);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input bit junk);
    exp_t e;
    wait_idle();
    bus.start  = 1'b1;
    bus.funct3 = op;
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    e.op  = op;
    e.res = exp_res;
    e.cyc = cyc + 1 + lat_of(op, a, b);
    sb_q.push_back(e);
    last_res = exp_res;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.SrcAE  = $urandom;
    bus.SrcBE  = $urandom;
    chk("busy_after_accept", {31'h0, bus.busy}, 32'h1);
    drain(junk);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.funct3 = '0;
    bus.SrcAE  = '0;
    bus.SrcBE  = '0;

    repeat (3) @(negedge clk);
    chk("reset_busy",   {31'h0, bus.busy}, 32'h0);
    chk("reset_done",   {31'h0, bus.done}, 32'h0);
    chk("reset_result", bus.result,        32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    issue(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    issue(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    issue(MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
    issue(MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);
    issue(MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
    issue(MD_DIVU,   32'd100,       32'd7,         32'd14,        1'b0);
    issue(MD_REMU,   32'd100,       32'd7,         32'd2,         1'b1);
    issue(MD_DIV,    32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 1'b0);
    issue(MD_REMU,   32'd5,         32'h0,         32'd5,         1'b1);
    issue(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    issue(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1);
    issue(MD_DIVU,   32'd999,       32'd10,        32'd99,        1'b0);

    // kill together with start in IDLE: nothing accepted
    wait_idle();
    bus.start = 1'b1; bus.kill = 1'b1; bus.funct3 = MD_DIVU; bus.SrcAE = 32'd50; bus.SrcBE = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.kill = 1'b0;
    chk("kill_idle_busy", {31'h0, bus.busy}, 32'h0);

    // DIVU aborted ten cycles after the start cycle
    bus.start = 1'b1; bus.funct3 = MD_DIVU; bus.SrcAE = 32'd1000; bus.SrcBE = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("kill_pre_busy", {31'h0, bus.busy}, 32'h1);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    chk("kill_busy_fall", {31'h0, bus.busy}, 32'h0);
    chk("kill_result_hold", bus.result, last_res);
    repeat (40) @(negedge clk);
    chk("kill_result_later", bus.result, last_res);
    issue(MD_DIVU, 32'd1000, 32'd9, 32'd111, 1'b1);
    issue(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);

    // asynchronous reset in the middle of an operation
    wait_idle();
    bus.start = 1'b1; bus.funct3 = RST_OP; bus.SrcAE = 32'd77; bus.SrcBE = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midop_rst_busy",   {31'h0, bus.busy}, 32'h0);
    chk("midop_rst_done",   {31'h0, bus.done}, 32'h0);
    chk("midop_rst_result", bus.result,        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b, ref_model(op, a, b), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
